// File: rtl/decoder_onehot_pipe.sv
// ---------------------------------------------------------------------------
// decoder_onehot_pipe
//
// Purpose:
//   Single-stage, valid/ready pipelined binary-to-one-hot decoder. An index
//   accepted on a_i is decoded and registered, so the result appears on out_o
//   the cycle after acceptance. An optional thermometer mode sets every bit up
//   to and including the index. Indices at or above OUT_N produce an all-zero
//   vector and raise err_o.
//
// Configuration macro:
//   DECODER_THERMO_EN - when defined, mode_i selects one-hot (0) or
//                       thermometer (1). When undefined, the block is one-hot
//                       only and mode_i is ignored. The port list is the same
//                       in both builds.
//
// Parameters:
//   IN_W  - index width in bits (1..8)
//   OUT_N - number of output lines (2..2**IN_W)
//
// Ports:
//   clk_i    in   1      clock; all state updates on the rising edge
//   rst_i    in   1      synchronous active-high reset
//   valid_i  in   1      upstream index valid
//   ready_o  out  1      block can accept an index this cycle
//   a_i      in   IN_W   binary index to decode
//   mode_i   in   1      0 = one-hot, 1 = thermometer (sampled with a_i)
//   valid_o  out  1      out_o/err_o hold a decoded result
//   ready_i  in   1      downstream accepts the result
//   out_o    out  OUT_N  registered decoded vector
//   err_o    out  1      registered flag: captured a_i >= OUT_N
// ---------------------------------------------------------------------------
module decoder_onehot_pipe #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_N = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  a_i,
  input  logic             mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_N-1:0] out_o,
  output logic             err_o
);

  // One extra bit so OUT_N == 2**IN_W is representable for the range check.
  localparam logic [IN_W:0] OUT_N_W = (IN_W + 1)'(OUT_N);

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_next;

  logic [OUT_N-1:0]  r_out;
  logic              r_err;

  logic              w_accept;
  logic              w_handoff;
  logic [IN_W:0]     w_a_ext;
  logic              w_oor;
  logic [OUT_N-1:0]  w_onehot;
  logic [OUT_N-1:0]  w_dec;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign valid_o   = (r_state == StFull);
  assign ready_o   = !valid_o || ready_i;
  assign w_accept  = valid_i && ready_o;
  assign w_handoff = valid_o && ready_i;

  // -------------------------------------------------------------------------
  // Decode (feeds the output register only; out_o is never combinational)
  // -------------------------------------------------------------------------
  assign w_a_ext = {1'b0, a_i};
  assign w_oor   = (w_a_ext >= OUT_N_W);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < int'(OUT_N); i++) begin
      w_onehot[i] = (w_a_ext == (IN_W + 1)'(i));
    end
  end

`ifdef DECODER_THERMO_EN
  logic [OUT_N-1:0] w_thermo;

  always_comb begin
    w_thermo = '0;
    for (int i = 0; i < int'(OUT_N); i++) begin
      w_thermo[i] = ((IN_W + 1)'(i) <= w_a_ext);
    end
  end

  always_comb begin
    w_dec = '0;
    if (!w_oor) begin
      w_dec = mode_i ? w_thermo : w_onehot;
    end
  end
`else
  // mode_i is intentionally unused in the one-hot-only build.
  logic w_unused_mode;
  assign w_unused_mode = mode_i;

  always_comb begin
    w_dec = '0;
    if (!w_oor) begin
      w_dec = w_onehot;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Occupancy FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_state_next = StFull;
        end
      end
      StFull: begin
        // While full, an accept can only happen alongside a handoff, so the
        // state stays full and the register below takes the new result.
        if (w_handoff && !w_accept) begin
          w_state_next = StEmpty;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

  // -------------------------------------------------------------------------
  // Result register: loads only on accept, so it holds under backpressure.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_out <= w_dec;
      r_err <= w_oor;
    end
  end

  assign out_o = r_out;
  assign err_o = r_err;

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
module tb_decoder_onehot_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic [4:0]  a;
  logic        mode;

  logic        ready_o;
  logic        valid_o;
  logic [31:0] out_o;
  logic        err_o;

  logic        ready20_o;
  logic        valid20_o;
  logic [19:0] out20_o;
  logic        err20_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  decoder_onehot_pipe #(.IN_W(5), .OUT_N(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a),
    .mode_i  (mode),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .out_o   (out_o),
    .err_o   (err_o)
  );

  decoder_onehot_pipe #(.IN_W(5), .OUT_N(20)) dut20 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready20_o),
    .a_i     (a),
    .mode_i  (mode),
    .valid_o (valid20_o),
    .ready_i (ready_i),
    .out_o   (out20_o),
    .err_o   (err20_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_th5;
  logic [31:0] exp_th31;

  initial begin
`ifdef DECODER_THERMO_EN
    exp_th5  = 32'h0000003F;
    exp_th31 = 32'hFFFFFFFF;
`else
    exp_th5  = 32'h00000020;
    exp_th31 = 32'h80000000;
`endif
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a = '0; mode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_out",   64'(out_o),   64'h0);
    check("rst_err",   64'(err_o),   64'h0);
    check("rst_ready", 64'(ready_o), 64'h1);
    tick();
    check("idle_valid", 64'(valid_o), 64'h0);

    // Single accept, one-cycle latency.
    valid_i = 1'b1; a = 5'd5; mode = 1'b0;
    tick();
    check("oh5_out",   64'(out_o),   64'h00000020);
    check("oh5_valid", 64'(valid_o), 64'h1);
    check("oh5_err",   64'(err_o),   64'h0);

    // Back-to-back accepts, including the top index.
    a = 5'd0;
    tick();
    check("oh0_out",   64'(out_o),   64'h00000001);
    check("oh0_ready", 64'(ready_o), 64'h1);
    a = 5'd1;
    tick();
    check("oh1_out",   64'(out_o),   64'h00000002);
    check("oh1_ready", 64'(ready_o), 64'h1);
    a = 5'd31;
    tick();
    check("oh31_out",   64'(out_o),   64'h80000000);
    check("oh31_ready", 64'(ready_o), 64'h1);
    check("oh31_err",   64'(err_o),   64'h0);

    // Thermometer mode (one-hot when the feature is compiled out).
    mode = 1'b1; a = 5'd5;
    tick();
    check("th5_out", 64'(out_o), 64'(exp_th5));
    a = 5'd31;
    tick();
    check("th31_out", 64'(out_o), 64'(exp_th31));
    a = 5'd0;
    tick();
    check("th0_out", 64'(out_o), 64'h00000001);

    // Backpressure: result and valid hold, new inputs ignored.
    mode = 1'b0; a = 5'd10;
    tick();
    check("bp_cap_out", 64'(out_o), 64'h00000400);
    ready_i = 1'b0; a = 5'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_out",   64'(out_o),   64'h00000400);
      check("bp_hold_valid", 64'(valid_o), 64'h1);
      check("bp_hold_ready", 64'(ready_o), 64'h0);
    end
    mode = 1'b1;
    tick();
    check("bp_mode_ign", 64'(out_o), 64'h00000400);
    mode = 1'b0;
    ready_i = 1'b1;
    #1;
    check("bp_rel_ready", 64'(ready_o), 64'h1);
    tick();
    check("bp_next_out",   64'(out_o),   64'h00100000);
    check("bp_next_valid", 64'(valid_o), 64'h1);

    // Handoff without accept empties the stage.
    valid_i = 1'b0;
    tick();
    check("drain_valid", 64'(valid_o), 64'h0);
    check("drain_ready", 64'(ready_o), 64'h1);
    ready_i = 1'b0;
    tick();
    check("empty_hold_valid", 64'(valid_o), 64'h0);
    check("empty_ready",      64'(ready_o), 64'h1);

    // Accept while empty even with ready_i low, then hold.
    valid_i = 1'b1; a = 5'd3;
    tick();
    check("full_bp_out",   64'(out_o),   64'h00000008);
    check("full_bp_valid", 64'(valid_o), 64'h1);

    // Reset while full and stalled, with an accept attempt pending.
    rst = 1'b1; a = 5'd7;
    tick();
    check("mrst_valid", 64'(valid_o), 64'h0);
    check("mrst_out",   64'(out_o),   64'h0);
    check("mrst_err",   64'(err_o),   64'h0);
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    tick();
    check("mrst_ready", 64'(ready_o), 64'h1);
    check("mrst_empty", 64'(valid_o), 64'h0);

    // Out-of-range handling on the OUT_N=20 instance.
    valid_i = 1'b1; mode = 1'b0; a = 5'd20;
    tick();
    check("n20_a20_out", 64'(out20_o), 64'h0);
    check("n20_a20_err", 64'(err20_o), 64'h1);
    check("n32_a20_err", 64'(err_o),   64'h0);
    check("n32_a20_out", 64'(out_o),   64'h00100000);
    a = 5'd19;
    tick();
    check("n20_a19_out", 64'(out20_o), 64'h80000);
    check("n20_a19_err", 64'(err20_o), 64'h0);
    mode = 1'b1; a = 5'd25;
    tick();
    check("n20_th25_out", 64'(out20_o), 64'h0);
    check("n20_th25_err", 64'(err20_o), 64'h1);
    mode = 1'b0; a = 5'd4;
    tick();
    check("n20_a4_out", 64'(out20_o), 64'h10);
    check("n20_a4_err", 64'(err20_o), 64'h0);
    valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_pipe.md
DECODER_ONEHOT_PIPE -- requirements
Module: decoder_onehot_pipe

Interface
REQ-001 Parameter IN_W, default 5, meaning index width in bits (1..8).
REQ-002 Parameter OUT_N, default 32, meaning number of output lines (2..2**IN_W).
REQ-003 Port clk_i  input  1  meaning single clock; all state updates on rising edge.
REQ-004 Port rst_i  input  1  meaning reset, synchronous, active-high.
REQ-005 Port valid_i  input  1  meaning upstream index valid.
REQ-006 Port ready_o  output  1  meaning block can accept an index this cycle.
REQ-007 Port a_i  input  IN_W  meaning binary index to decode.
REQ-008 Port mode_i  input  1  meaning 0 = one-hot, 1 = thermometer; sampled with a_i.
REQ-009 Port valid_o  output  1  meaning out_o/err_o hold a decoded result.
REQ-010 Port ready_i  input  1  meaning downstream accepts the result.
REQ-011 Port out_o  output  OUT_N  meaning registered decoded vector.
REQ-012 Port err_o  output  1  meaning registered flag: captured a_i >= OUT_N.

Function
REQ-013 Accept occurs when valid_i && ready_o at a rising edge; a_i and mode_i are captured only on accept.
REQ-014 Output handoff occurs when valid_o && ready_i at a rising edge.
REQ-015 ready_o = !valid_o || ready_i, combinational; no combinational path from a_i to out_o.
REQ-016 Latency: result is visible on out_o/valid_o the cycle after accept; throughput is one index per cycle while ready_i is high.
REQ-017 One-hot mode: out_o bit a_i = 1, all other bits 0.
REQ-018 Thermometer mode: out_o bits [a_i:0] = 1, all higher bits 0.
REQ-019 Out-of-range (a_i >= OUT_N): out_o = all zeros and err_o = 1 in both modes; otherwise err_o = 0.
REQ-020 State: EMPTY (valid_o = 0) and FULL (valid_o = 1).
REQ-021 EMPTY to FULL on accept. FULL to FULL on simultaneous handoff and accept, with the new result replacing the old in the same edge. FULL to EMPTY on handoff without accept. Otherwise the state holds.
REQ-022 While FULL and ready_i = 0: out_o, err_o and valid_o hold stable; a_i and mode_i changes are ignored.
REQ-023 valid_o never drops without a handoff, except on reset.

Reset
REQ-024 rst_i high at a rising edge forces EMPTY: valid_o = 0, out_o = 0, err_o = 0; this takes precedence over any accept or handoff in the same cycle.
REQ-025 Reset mid-operation discards any held result with no handoff; ready_o = 1 in the cycle after reset deasserts.

Configuration
REQ-026 Macro DECODER_THERMO_EN defined: mode_i is honoured per REQ-017/REQ-018.
REQ-027 Macro DECODER_THERMO_EN undefined: mode_i is ignored, the block is one-hot only, and no thermometer logic is synthesised; the port list is unchanged.

Verification (IN_W=5, OUT_N=32, macro defined unless stated)
REQ-028 Reset, then a_i=5, mode_i=0, valid_i=1, ready_i=1 -> next cycle out_o=32'h00000020, valid_o=1, err_o=0.
REQ-029 Back-to-back accepts of a_i=0,1,31 with ready_i=1 -> out_o = 32'h00000001, 32'h00000002, 32'h80000000 on consecutive cycles; ready_o stays 1.
REQ-030 Thermometer: a_i=5, mode_i=1 -> out_o=32'h0000003F; a_i=31 -> 32'hFFFFFFFF.
REQ-031 Backpressure: capture a_i=10, hold ready_i=0 for 3 cycles while driving a_i=20 -> out_o stays 32'h00000400 and ready_o=0; on ready_i=1 the next result is 32'h00100000.
REQ-032 OUT_N=20, a_i=20 -> out_o=0, err_o=1; a_i=19 -> out_o=20'h80000, err_o=0.
REQ-033 Assert rst_i while FULL with ready_i=0 -> valid_o=0, out_o=0 the next cycle. With the macro undefined, a_i=5, mode_i=1 -> out_o=32'h00000020.
